// File: rtl/rand_share_arb.sv
// Round-robin arbiter that shares one free-running random source among N_REQ requesters,
// with a fixed decorrelation gap after each transfer or abort.
module rand_share_arb #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int GAP   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [W-1:0]               rand_in,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           valid,
    output logic [W-1:0]               rand_out,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic                       busy
);

    // state | meaning
    // IDLE  | no offer; arbitrate among active requests
    // GRANT | rand_out offered to gnt_id until ack or withdrawal
    // GAP   | decorrelation wait, GAP cycles, no grants
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP_S = 2'd2
    } state_t;

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [3:0] GAP_LOAD = 4'(GAP);

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  valid_nxt;
    logic [W-1:0]      rand_nxt;
    logic [ID_W-1:0]   gnt_nxt;
    logic [ID_W-1:0]   last_grant, last_nxt;
    logic [3:0]        gap_cnt, gap_nxt;

    logic              rr_hit;
    logic [ID_W-1:0]   rr_winner;
    logic [ID_W-1:0]   cand;
    logic [N_REQ-1:0]  onehot;

    // search starts one past the last completed grant and wraps
    always_comb begin
        rr_hit    = 1'b0;
        rr_winner = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!rr_hit && req[cand]) begin
                rr_hit    = 1'b1;
                rr_winner = cand;
            end
        end
        onehot            = '0;
        onehot[rr_winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = valid;
        rand_nxt  = rand_out;
        gnt_nxt   = gnt_id;
        last_nxt  = last_grant;
        gap_nxt   = gap_cnt;
        unique case (state)
            IDLE: begin
                valid_nxt = '0;
                if (rr_hit) begin
                    state_nxt = GRANT;
                    valid_nxt = onehot;
                    rand_nxt  = rand_in;
                    gnt_nxt   = rr_winner;
                end
            end
            GRANT: begin
                // an ack coinciding with withdrawal still counts as a transfer
                if (ack[gnt_id]) begin
                    state_nxt = GAP_S;
                    valid_nxt = '0;
                    last_nxt  = gnt_id;
                    gap_nxt   = GAP_LOAD;
                end else if (!req[gnt_id]) begin
                    state_nxt = GAP_S;
                    valid_nxt = '0;
                    gap_nxt   = GAP_LOAD;
                end
            end
            GAP_S: begin
                valid_nxt = '0;
                if (gap_cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = '0;
                gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            rand_out   <= '0;
            gnt_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            valid      <= valid_nxt;
            rand_out   <= rand_nxt;
            gnt_id     <= gnt_nxt;
            last_grant <= last_nxt;
            gap_cnt    <= gap_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rand_share_arb.sv
// Bench for rand_share_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model (grant owner, timestamps for the gap window).
module tb_rand_share_arb;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int GAP = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] rand_in = '0;
    logic [N-1:0] req = '0;
    logic [N-1:0] ack = '0;
    logic [N-1:0] valid;
    logic [W-1:0] rand_out;
    logic [1:0]   gnt_id;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model: who owns the offer, and when the gap window closes
    bit m_granted;
    bit m_in_gap;
    int m_gnt;
    int m_last;
    int m_rand;
    int m_idle_at;

    rand_share_arb #(.N_REQ(N), .W(W), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .rand_in(rand_in), .req(req), .ack(ack),
        .valid(valid), .rand_out(rand_out), .gnt_id(gnt_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & 1) != 0;
    endfunction

    task automatic model_reset();
        m_granted = 0;
        m_in_gap  = 0;
        m_gnt     = 0;
        m_last    = N - 1;
        m_rand    = 0;
        m_idle_at = 0;
    endtask

    // advance the model across one rising edge using the inputs present now
    task automatic model_tick();
        if (m_granted) begin
            if (bit_of(ack, m_gnt) || !bit_of(req, m_gnt)) begin
                if (bit_of(ack, m_gnt)) m_last = m_gnt;
                m_granted = 0;
                m_in_gap  = 1;
                m_idle_at = cyc + GAP + 1;
            end
        end else if (m_in_gap) begin
            if (cyc + 1 >= m_idle_at) m_in_gap = 0;
        end else if (req != 0) begin
            for (int k = 1; k <= N; k++) begin
                if (!m_granted && bit_of(req, (m_last + k) % N)) begin
                    m_granted = 1;
                    m_gnt     = (m_last + k) % N;
                    m_rand    = int'(rand_in);
                end
            end
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(valid), m_granted ? (32'd1 << m_gnt) : 32'd0);
        check("rand_out", 32'(rand_out), 32'(m_rand));
        check("gnt_id", 32'(gnt_id), 32'(m_gnt));
        check("busy", 32'(busy), 32'(m_granted || m_in_gap));
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // reset raised mid-cycle; outputs must clear before any clock edge
    task automatic apply_reset();
        reset = 1'b1;
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rand", 32'(rand_out), 32'd0);
        check("rst_gnt", 32'(gnt_id), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int rises;
        int last_rise;
        int last_xfer;
        logic [N-1:0] prev_valid;

        model_reset();
        #1;
        apply_reset();

        // single requester, ack on third valid cycle, then the gap
        req = 4'b0001; rand_in = 4'd9;
        step();
        check("r29_valid", 32'(valid), 32'h1);
        check("r29_rand", 32'(rand_out), 32'd9);
        run(2);
        ack = 4'b0001;
        step();
        check("r29_ack_valid", 32'(valid), 32'd0);
        ack = '0; req = '0;
        for (int g = 2; g <= GAP; g++) begin
            step();
            check("r29_gap_busy", 32'(busy), 32'd1);
        end
        step();
        check("r29_idle_busy", 32'(busy), 32'd0);

        // all requesting, immediate ack: rotation and spacing
        apply_reset();
        req = 4'b1111; ack = 4'b1111; rand_in = 4'd3;
        rises = 0; last_rise = 0; prev_valid = '0;
        for (int i = 0; i < 40 && rises < 5; i++) begin
            step();
            if (valid != 0 && prev_valid == 0) begin
                check("r30_order", 32'(gnt_id), 32'(exp_order[rises]));
                if (rises > 0) check("r30_spacing", 32'(cyc - last_rise), 32'(GAP + 2));
                last_rise = cyc;
                rises++;
            end
            prev_valid = valid;
        end
        check("r30_rises", 32'(rises), 32'd5);

        // rand_out frozen while waiting for a late ack
        apply_reset();
        req = 4'b0100; ack = '0; rand_in = 4'd5;
        step();
        for (int i = 0; i < 10; i++) begin
            rand_in = 4'($urandom_range(2, 15));
            step();
            check("r31_hold", 32'(rand_out), 32'd5);
        end
        ack = 4'b0100;
        step();
        ack = '0; req = '0;
        run(GAP);

        // withdrawal does not advance round-robin
        apply_reset();
        req = 4'b0001; step();
        ack = 4'b0001; step();
        ack = '0; req = '0; run(GAP);
        req = 4'b0010; step();
        check("r32_gnt1", 32'(gnt_id), 32'd1);
        req = '0; step();
        check("r32_abort_valid", 32'(valid), 32'd0);
        check("r32_abort_busy", 32'(busy), 32'd1);
        req = 4'b0011; run(GAP + 1);
        check("r32_regrant", 32'(valid), 32'b0010);

        // foreign acks ignored
        apply_reset();
        req = 4'b0001; step();
        ack = 4'b1110; step();
        check("r33_hold", 32'(valid), 32'b0001);
        ack = 4'b0001; step();
        ack = '0; req = '0; run(GAP);

        // reset in the middle of a grant
        req = 4'b0100; step();
        check("r34_pre", 32'(valid), 32'b0100);
        req = 4'b0101;
        apply_reset();
        step();
        check("r34_after", 32'(valid), 32'b0001);

        // randomized traffic
        apply_reset();
        last_xfer = -1000;
        prev_valid = valid;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom());
            ack = 4'($urandom());
            rand_in = 4'($urandom_range(2, 15));
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
                last_xfer = -1000;
                prev_valid = valid;
            end else begin
                if ((valid & ack) != 0) last_xfer = cyc;
                step();
                if (valid != 0 && prev_valid == 0 && last_xfer >= 0)
                    check("rnd_spacing", 32'((cyc - last_xfer) >= GAP + 2), 32'd1);
                check("rnd_onehot", 32'($countones(valid) <= 1), 32'd1);
                prev_valid = valid;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
